// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - static / bimodal / gshare conditional-branch predictor with perf counters
module branch_predictor #(
  parameter int MODE      = 2,
  parameter int IDX_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [31:0]         d_IR,
  input  logic [31:0]         d_PC,
  output logic                d_predict,
  output logic [IDX_BITS-1:0] d_idx,
  input  logic                e_update,
  input  logic [IDX_BITS-1:0] e_idx,
  input  logic                e_taken,
  input  logic                e_mispredict,
  output logic                busy,
  output logic [31:0]         br_count,
  output logic [31:0]         mp_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] WNT     = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam state_t RESET_STATE = (MODE == 0) ? S_RUN : S_INIT;

  state_t              state;
  logic [IDX_BITS-1:0] sweep_ptr;
  logic [HIST_BITS-1:0] ghr;
  logic [CTR_BITS-1:0] ctr_table [ENTRIES];

  logic                is_b;
  logic [IDX_BITS-1:0] pc_idx;
  logic [IDX_BITS-1:0] idx;
  logic                run_update;
  logic                unused_bits;

  assign unused_bits = ^{d_IR[30:7], d_PC[31:IDX_BITS+2], d_PC[1:0]};

  assign is_b       = (d_IR[6:0] == 7'b1100011);
  assign pc_idx     = d_PC[IDX_BITS+1:2];
  assign run_update = (state == S_RUN) && e_update;

  always_comb begin
    idx = pc_idx;
    if (MODE == 2) idx = pc_idx ^ IDX_BITS'(ghr);
  end

  assign d_idx = idx;

  // While the table is being swept its contents are meaningless, so fall back to BTFN.
  assign d_predict = is_b & (((MODE == 0) || busy) ? d_IR[31] : ctr_table[idx][CTR_BITS-1]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= RESET_STATE;
      sweep_ptr <= '0;
      busy      <= (MODE != 0);
    end else begin
      case (state)
        S_INIT: begin
          sweep_ptr <= sweep_ptr + 1'b1;
          if (sweep_ptr == '1) begin
            state <= S_RUN;
            busy  <= 1'b0;
          end
        end
        S_RUN:   state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  // History is non-speculative: it only advances on resolved branches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ghr <= '0;
    end else if ((MODE == 2) && run_update) begin
      ghr <= {ghr[HIST_BITS-2:0], e_taken};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_count <= '0;
      mp_count <= '0;
    end else if (e_update) begin
      br_count <= br_count + 32'd1;
      if (e_mispredict) mp_count <= mp_count + 32'd1;
    end
  end

  // Table has no reset; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (MODE != 0) begin
      if (state == S_INIT) begin
        ctr_table[sweep_ptr] <= WNT;
      end else if (e_update) begin
        if (e_taken && (ctr_table[e_idx] != CTR_MAX))
          ctr_table[e_idx] <= ctr_table[e_idx] + 1'b1;
        else if (!e_taken && (ctr_table[e_idx] != CTR_MIN))
          ctr_table[e_idx] <= ctr_table[e_idx] - 1'b1;
      end
    end
  end

endmodule
